data_mem_unit: RTL and testbench
================================

// Module: data_mem_unit
// PURPOSE
// - Data memory subsystem on the CPU's load/store port: MemAddr, toMem, WriteEn, ReadEn, addMemControl.
// - Byte-addressed word RAM with byte/half/word lane steering and load extension.
// - Holds one memory-mapped output register (io_out) for board display.
// - Power-up clear FSM zeroes the RAM after reset.
// - Reads are combinational (single-cycle CPU); writes commit on posedge clk.
// PARAMETERS
// - DEPTH_WORDS  256            RAM size in 32-bit words; power of 2, >=4
// - IO_ADDR      32'hFFFF_FFF0  word address of io_out register; bits[1:0]=00
// PORTS
// - clk          in   1   system clock, all state updates on posedge
// - rst          in   1   synchronous active-high reset
// - MemAddr      in   32  byte address from CPU (ALU result)
// - toMem        in   32  store data; lane 0 = toMem[7:0]
// - WriteEn      in   1   store request this cycle
// - ReadEn       in   1   load request this cycle
// - addMemControl in  2   size, instr[13:12]: 00 byte, 01 half, 10 word, 11 reserved
// - unsignedLd   in   1   instr[14]; 1 = LBU/LHU zero-extend, 0 = sign-extend
// - fromMem      out  32  load data to CPU (combinational)
// - io_out       out  32  memory-mapped output register
// - init_busy    out  1   1 while clear FSM runs; loads/stores are ignored
// - misalign     out  1   combinational: current access is misaligned or reserved size
// - misalign_cnt out  8   saturating count of rejected accesses
// BEHAVIOUR
// - Reset, applied on the same posedge:
//   - io_out = 0, misalign_cnt = 0, state = CLEAR, clr_idx = 0, init_busy = 1.
// - FSM CLEAR:
//   - Each cycle writes RAM[clr_idx] = 0 and increments clr_idx.
//   - Leaves for RUN on the cycle clr_idx = DEPTH_WORDS-1 is written.
//   - CLEAR lasts exactly DEPTH_WORDS cycles after rst deasserts.
//   - rst during CLEAR restarts the sequence at clr_idx = 0.
// - FSM RUN: init_busy = 0. Only rst leaves RUN, which returns the FSM to CLEAR.
// - Addressing:
//   - word index = MemAddr[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so addresses alias modulo RAM size.
//   - Exception: a word-aligned match of MemAddr[31:2] with IO_ADDR[31:2] selects io_out, not RAM.
// - Alignment:
//   - half requires MemAddr[0] = 0; word requires MemAddr[1:0] = 0.
//   - Size 11 always counts as misaligned.
//   - misalign = (ReadEn | WriteEn) & (violation).
// - Stores, committed at posedge when WriteEn & !init_busy & !misalign:
//   - byte: lane MemAddr[1:0] <= toMem[7:0].
//   - half: lanes {MemAddr[1],0} and {MemAddr[1],1} <= toMem[15:0].
//   - word: all four lanes <= toMem.
//   - Lane rules apply identically to io_out.
// - Loads:
//   - fromMem = 0 if !ReadEn, init_busy or misalign.
//   - Otherwise the selected byte or half is right-justified, then sign- or zero-extended per unsignedLd.
//   - Word loads return the full word.
// - Simultaneous ReadEn & WriteEn: fromMem returns pre-write contents; the write commits at the edge.
// - misalign_cnt:
//   - Increments at posedge when misalign & !init_busy.
//   - Saturates at 8'hFF.
//   - Not incremented while init_busy.
// TESTING
// - Clear: rst 1 cycle, then count -> init_busy high exactly DEPTH_WORDS cycles; every word then reads 0.
// - Byte lanes: SW 0x11223344 @0x8, then SB 0xAA @0xA -> LW @0x8 = 0x11AA3344.
// - Extension: SH 0x8001 @0x10 -> LH = 0xFFFF8001, LHU = 0x00008001; byte 0x80 -> LB 0xFFFFFF80, LBU 0x00000080.
// - Misalign: SW @0x6, LH @0x3, size 11 -> no RAM change, fromMem 0, misalign_cnt = 3; 300 faults -> saturates at 0xFF.
// - IO register:
//   - SW 0xCAFEF00D @IO_ADDR -> io_out = 0xCAFEF00D, LW reads it back; RAM unchanged.
//   - SB 0x55 @IO_ADDR+1 -> io_out = 0xCAFE550D.
// - Reset mid-op: rst at CLEAR cycle 100 -> full DEPTH_WORDS restart; rst in RUN -> io_out 0, RAM re-cleared.

Source files
------------

// File: rtl/data_mem_unit.sv
// Data memory on the CPU load/store port. The RAM is built from four byte-lane
// instances, with one memory-mapped io_out register and a clear FSM that runs after reset.

module data_mem_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module data_mem_unit #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemAddr,
  input  logic [31:0] toMem,
  input  logic        WriteEn,
  input  logic        ReadEn,
  input  logic [1:0]  addMemControl,
  input  logic        unsignedLd,
  output logic [31:0] fromMem,
  output logic [31:0] io_out,
  output logic        init_busy,
  output logic        misalign,
  output logic [7:0]  misalign_cnt
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_WORDS);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                         state, state_nxt;
  logic [AW-1:0]                  clr_idx, clr_idx_nxt;
  logic [AW-1:0]                  widx;
  logic                           is_io, viol, st_ok;
  logic [NUM_LANES-1:0]           bmask;
  logic [NUM_LANES-1:0][7:0]      wlane, rlane, io_q;
  logic [31:0]                    rword, rsh;

  // ---- clear FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        // depth is a power of two, so all-ones marks the last word
        if (&clr_idx) state_nxt = RUN;
      end
      RUN:     clr_idx_nxt = '0;
      default: state_nxt = CLEAR;
    endcase
  end

  assign init_busy = (state == CLEAR);

  // ---- decode ----
  assign widx  = MemAddr[AW+1:2];
  assign is_io = (MemAddr[31:2] == IO_ADDR[31:2]);

  always_comb begin
    case (addMemControl)
      2'b00:   viol = 1'b0;
      2'b01:   viol = MemAddr[0];
      2'b10:   viol = |MemAddr[1:0];
      default: viol = 1'b1;
    endcase
  end

  assign misalign = (ReadEn | WriteEn) & viol;
  assign st_ok    = WriteEn & ~init_busy & ~misalign;

  // store data is replicated across lanes; bmask picks which lanes commit
  always_comb begin
    case (addMemControl)
      2'b00: begin
        bmask = 4'b0001 << MemAddr[1:0];
        wlane = {4{toMem[7:0]}};
      end
      2'b01: begin
        bmask = MemAddr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{toMem[15:0]}};
      end
      default: begin
        bmask = 4'b1111;
        wlane = toMem;
      end
    endcase
  end

  // ---- byte-lane RAM ----
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_mem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (init_busy | (st_ok & ~is_io & bmask[g])),
      .waddr (init_busy ? clr_idx : widx),
      .wdata (init_busy ? 8'h00 : wlane[g]),
      .raddr (widx),
      .rdata (rlane[g])
    );
  end

  // ---- io_out register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      io_q <= '0;
    end else if (st_ok & is_io) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (bmask[i]) io_q[i] <= wlane[i];
    end
  end

  assign io_out = io_q;

  // ---- load path ----
  assign rword = is_io ? io_q : rlane;
  assign rsh   = rword >> {MemAddr[1:0], 3'b000};

  always_comb begin
    fromMem = '0;
    if (ReadEn & ~init_busy & ~misalign) begin
      case (addMemControl)
        2'b00:   fromMem = unsignedLd ? {24'h0, rsh[7:0]}  : {{24{rsh[7]}}, rsh[7:0]};
        2'b01:   fromMem = unsignedLd ? {16'h0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
        default: fromMem = rword;
      endcase
    end
  end

  // ---- fault counter ----
  always_ff @(posedge clk) begin
    if (rst)
      misalign_cnt <= '0;
    else if (misalign & ~init_busy & (misalign_cnt != 8'hFF))
      misalign_cnt <= misalign_cnt + 8'd1;
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table for loads/stores plus
// hand sequences for clear timing, reset restarts, io_out and counter saturation.

module tb_data_mem_unit;
  localparam int          DEPTH = 256;
  localparam logic [31:0] IOA   = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MemAddr, toMem;
  logic        WriteEn, ReadEn, unsignedLd;
  logic [1:0]  addMemControl;
  logic [31:0] fromMem, io_out;
  logic        init_busy, misalign;
  logic [7:0]  misalign_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .IO_ADDR(IOA)) dut (
    .clk(clk), .rst(rst), .MemAddr(MemAddr), .toMem(toMem),
    .WriteEn(WriteEn), .ReadEn(ReadEn), .addMemControl(addMemControl),
    .unsignedLd(unsignedLd), .fromMem(fromMem), .io_out(io_out),
    .init_busy(init_busy), .misalign(misalign), .misalign_cnt(misalign_cnt)
  );

  typedef struct {
    logic        we, re;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, data, exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WriteEn = 0; ReadEn = 0; addMemControl = 2'b10; unsignedLd = 0;
    MemAddr = 0; toMem = 0;
  endtask

  task automatic acc(input logic we, input logic re, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] d);
    WriteEn = we; ReadEn = re; addMemControl = sz; unsignedLd = uns;
    MemAddr = a; toMem = d;
    #1;
  endtask

  // counts cycles with init_busy high, bounded so a stuck FSM still ends the run
  task automatic count_clear(input string name);
    int n = 0;
    while (init_busy === 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk(name, n, DEPTH);
  endtask

  initial begin
    int nz;
    idle();
    rst = 1;
    step();
    step();
    #1;
    chk("rst_busy", {31'h0, init_busy}, 1);
    chk("rst_io", io_out, 0);
    chk("rst_cnt", {24'h0, misalign_cnt}, 0);
    rst = 0;
    count_clear("clear_len");

    nz = 0;
    for (int w = 0; w < DEPTH; w++) begin
      acc(0, 1, 2'b10, 0, w * 4, 0);
      if (fromMem !== 32'h0) nz++;
    end
    chk("cleared_words_nonzero", nz, 0);
    idle();

    //           we re sz    u  addr          data          exp_rd        mis
    tbl.push_back('{1, 0, 2'd2, 0, 32'h8,   32'h11223344, 32'h0,        0});
    tbl.push_back('{1, 0, 2'd0, 0, 32'hA,   32'h000000AA, 32'h0,        0});
    tbl.push_back('{0, 1, 2'd2, 0, 32'h8,   32'h0,        32'h11AA3344, 0});
    tbl.push_back('{0, 1, 2'd0, 0, 32'hA,   32'h0,        32'hFFFFFFAA, 0});
    tbl.push_back('{0, 1, 2'd0, 1, 32'hB,   32'h0,        32'h00000011, 0});
    tbl.push_back('{0, 1, 2'd1, 0, 32'hA,   32'h0,        32'h000011AA, 0});
    tbl.push_back('{0, 1, 2'd1, 1, 32'h8,   32'h0,        32'h00003344, 0});
    tbl.push_back('{1, 0, 2'd1, 0, 32'h10,  32'h12348001, 32'h0,        0});
    tbl.push_back('{0, 1, 2'd1, 0, 32'h10,  32'h0,        32'hFFFF8001, 0});
    tbl.push_back('{0, 1, 2'd1, 1, 32'h10,  32'h0,        32'h00008001, 0});
    tbl.push_back('{1, 0, 2'd0, 0, 32'h13,  32'h00000080, 32'h0,        0});
    tbl.push_back('{0, 1, 2'd0, 0, 32'h13,  32'h0,        32'hFFFFFF80, 0});
    tbl.push_back('{0, 1, 2'd0, 1, 32'h13,  32'h0,        32'h00000080, 0});
    tbl.push_back('{0, 1, 2'd2, 0, 32'h10,  32'h0,        32'h80008001, 0});
    tbl.push_back('{1, 0, 2'd2, 0, 32'h6,   32'hDEADBEEF, 32'h0,        1});
    tbl.push_back('{0, 1, 2'd1, 0, 32'h3,   32'h0,        32'h0,        1});
    tbl.push_back('{0, 1, 2'd3, 0, 32'h8,   32'h0,        32'h0,        1});
    tbl.push_back('{0, 0, 2'd2, 0, 32'h6,   32'h0,        32'h0,        0});
    tbl.push_back('{0, 1, 2'd2, 0, 32'h4,   32'h0,        32'h0,        0});
    tbl.push_back('{0, 1, 2'd2, 0, 32'h8,   32'h0,        32'h11AA3344, 0});
    tbl.push_back('{0, 0, 2'd2, 0, 32'h8,   32'h0,        32'h0,        0});
    tbl.push_back('{1, 1, 2'd2, 0, 32'h8,   32'h55667788, 32'h11AA3344, 0});
    tbl.push_back('{0, 1, 2'd2, 0, 32'h8,   32'h0,        32'h55667788, 0});
    tbl.push_back('{0, 1, 2'd2, 0, 32'h408, 32'h0,        32'h55667788, 0});

    foreach (tbl[i]) begin
      acc(tbl[i].we, tbl[i].re, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d_rd", i), fromMem, tbl[i].exp_rd);
      chk($sformatf("vec%0d_mis", i), {31'h0, misalign}, {31'h0, tbl[i].exp_mis});
      step();
    end
    idle();
    #1;
    chk("misalign_cnt_3", {24'h0, misalign_cnt}, 3);

    // io_out register
    acc(1, 0, 2'b10, 0, IOA, 32'hCAFEF00D);
    step();
    idle();
    #1;
    chk("io_sw", io_out, 32'hCAFEF00D);
    acc(0, 1, 2'b10, 0, IOA, 0);
    chk("io_lw", fromMem, 32'hCAFEF00D);
    acc(0, 1, 2'b10, 0, 32'h3F0, 0);
    chk("io_ram_alias_untouched", fromMem, 0);
    acc(1, 0, 2'b00, 0, IOA + 1, 32'h00000055);
    step();
    idle();
    #1;
    chk("io_sb", io_out, 32'hCAFE550D);
    acc(0, 1, 2'b00, 1, IOA + 1, 0);
    chk("io_lbu", fromMem, 32'h00000055);

    // counter saturation
    acc(0, 1, 2'b01, 0, 32'h1, 0);
    for (int i = 0; i < 300; i++) step();
    idle();
    #1;
    chk("cnt_sat", {24'h0, misalign_cnt}, 32'hFF);

    // reset in RUN, then reset again mid-clear at cycle 100
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("run_rst_io", io_out, 0);
    chk("run_rst_cnt", {24'h0, misalign_cnt}, 0);
    chk("run_rst_busy", {31'h0, init_busy}, 1);
    for (int i = 0; i < 100; i++) step();
    rst = 1;
    step();
    rst = 0;
    acc(1, 1, 2'b01, 0, 32'h1, 32'h1234);
    chk("busy_misalign_rd", fromMem, 0);
    acc(0, 1, 2'b10, 0, 32'h8, 0);
    chk("busy_rd_zero", fromMem, 0);
    acc(0, 1, 2'b01, 0, 32'h1, 0);
    count_clear("restart_clear_len");
    idle();
    #1;
    chk("busy_no_count", {24'h0, misalign_cnt}, 0);
    acc(0, 1, 2'b10, 0, 32'h8, 0);
    chk("reclear_word2", fromMem, 0);
    acc(0, 1, 2'b10, 0, 32'h10, 0);
    chk("reclear_word4", fromMem, 0);
    chk("reclear_io", io_out, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
